// File: rtl/vpp_meter.sv
// Peak-to-peak meter: per-window max/min of 8-bit ADC codes, scaled to mV by a restoring divider.
// Optional VPP_METER_AVG_EN: output is the mean of the last four divider results (one extra cycle of latency).
module vpp_meter #(
    parameter int WIN_LEN = 4096
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        isample_valid,
    input  logic [7:0]  isample,
    output logic [15:0] ovpp_mv,
    output logic        ovpp_valid,
    output logic [7:0]  omax,
    output logic [7:0]  omin,
    output logic        obusy
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_LOAD  = 2'd1;
    localparam logic [1:0]  ST_DIV   = 2'd2;
    localparam logic [1:0]  ST_DONE  = 2'd3;

    localparam logic [15:0] WIN_LAST  = 16'(WIN_LEN - 1);
    localparam logic [19:0] FULL_MV   = 20'd3300;
    localparam logic [19:0] ROUND_ADD = 20'd127;
    localparam logic [8:0]  CODE_SPAN = 9'd255;
    localparam logic [4:0]  ITER_LAST = 5'd19;

    // ------------------------------------------------------------------
    // Acquisition: window counter and running extremes
    // ------------------------------------------------------------------
    logic [15:0] win_cnt_reg;
    logic [7:0]  run_max_reg;
    logic [7:0]  run_min_reg;
    logic [7:0]  max_next;
    logic [7:0]  min_next;
    logic        win_first;
    logic        win_close;

    always_comb begin
        win_first = (win_cnt_reg == 16'd0);
        win_close = isample_valid && (win_cnt_reg == WIN_LAST);
        max_next  = (win_first || (isample > run_max_reg)) ? isample : run_max_reg;
        min_next  = (win_first || (isample < run_min_reg)) ? isample : run_min_reg;
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            win_cnt_reg <= 16'd0;
            run_max_reg <= 8'd0;
            run_min_reg <= 8'd0;
        end else if (isample_valid) begin
            win_cnt_reg <= win_close ? 16'd0 : win_cnt_reg + 16'd1;
            run_max_reg <= max_next;
            run_min_reg <= min_next;
        end
    end

    // ------------------------------------------------------------------
    // Divider FSM: quotient bits shift into num_reg as numerator bits leave
    // ------------------------------------------------------------------
    logic [1:0]  state_reg;
    logic [7:0]  diff_reg;
    logic [7:0]  omax_reg;
    logic [7:0]  omin_reg;
    logic [19:0] num_reg;
    logic [7:0]  rem_reg;
    logic [4:0]  iter_reg;

    logic [8:0]  rem_shift;
    logic        rem_ge;
    logic [7:0]  rem_step;
    logic [19:0] num_step;

    always_comb begin
        rem_shift = {rem_reg, num_reg[19]};
        rem_ge    = (rem_shift >= CODE_SPAN);
        rem_step  = rem_ge ? 8'(rem_shift - CODE_SPAN) : rem_shift[7:0];
        num_step  = {num_reg[18:0], rem_ge};
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_reg <= ST_IDLE;
            diff_reg  <= 8'd0;
            omax_reg  <= 8'd0;
            omin_reg  <= 8'd0;
            num_reg   <= 20'd0;
            rem_reg   <= 8'd0;
            iter_reg  <= 5'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // A close while the divider is busy is simply not seen here
                    if (win_close) begin
                        omax_reg  <= max_next;
                        omin_reg  <= min_next;
                        diff_reg  <= max_next - min_next;
                        state_reg <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    num_reg   <= 20'(diff_reg) * FULL_MV + ROUND_ADD;
                    rem_reg   <= 8'd0;
                    iter_reg  <= 5'd0;
                    state_reg <= ST_DIV;
                end
                ST_DIV: begin
                    num_reg  <= num_step;
                    rem_reg  <= rem_step;
                    iter_reg <= iter_reg + 5'd1;
                    if (iter_reg == ITER_LAST) begin
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    logic        div_done;
    logic [15:0] quotient;

    assign div_done = (state_reg == ST_DONE);
    assign quotient = num_reg[15:0];

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
    logic [15:0] vpp_mv_reg;
    logic        vpp_valid_reg;

`ifdef VPP_METER_AVG_EN
    logic [15:0] hist_reg  [4];
    logic [15:0] hist_next [4];
    logic        primed_reg;
    logic        avg_pend_reg;
    logic [17:0] hist_sum;
    logic [15:0] hist_avg;

    // Before the first result every slot takes the new value so the average starts settled
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hist
            if (gi == 0) begin : g_head
                assign hist_next[gi] = quotient;
            end else begin : g_tail
                assign hist_next[gi] = primed_reg ? hist_reg[gi-1] : quotient;
            end
        end
    endgenerate

    always_comb begin
        hist_sum = 18'(hist_reg[0]) + 18'(hist_reg[1]) + 18'(hist_reg[2]) + 18'(hist_reg[3]);
        hist_avg = 16'(hist_sum >> 2);
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            for (int i = 0; i < 4; i++) begin
                hist_reg[i] <= 16'd0;
            end
            primed_reg    <= 1'b0;
            avg_pend_reg  <= 1'b0;
            vpp_mv_reg    <= 16'd0;
            vpp_valid_reg <= 1'b0;
        end else begin
            avg_pend_reg  <= div_done;
            vpp_valid_reg <= avg_pend_reg;
            if (div_done) begin
                for (int i = 0; i < 4; i++) begin
                    hist_reg[i] <= hist_next[i];
                end
                primed_reg <= 1'b1;
            end
            if (avg_pend_reg) begin
                vpp_mv_reg <= hist_avg;
            end
        end
    end
`else
    always_ff @(posedge iclk) begin
        if (irst) begin
            vpp_mv_reg    <= 16'd0;
            vpp_valid_reg <= 1'b0;
        end else begin
            vpp_valid_reg <= div_done;
            if (div_done) begin
                vpp_mv_reg <= quotient;
            end
        end
    end
`endif

    assign ovpp_mv    = vpp_mv_reg;
    assign ovpp_valid = vpp_valid_reg;
    assign omax       = omax_reg;
    assign omin       = omin_reg;
    assign obusy      = (state_reg != ST_IDLE);

endmodule
